i2c_sram_embedded: RTL and testbench

- I2C-style slave wrapping a 256 x 16-bit synchronous SRAM, addressed by a 7-bit device address on `my_addr`.
- A master writes or reads one 16-bit word per transaction: device address + mode, 8-bit memory address, then two data bytes, high byte first.
- Sits on the board-level two-wire bus.
- Exposes debug outputs (current byte, received address/mode, FSM state) for observation.

---
 rtl/i2c_sram_pkg.sv | 22 ++
 rtl/i2c_sram_embedded_sram.sv | 17 +
 rtl/i2c_sram_embedded.sv | 139 +++++++++++++
 tb/tb_i2c_sram_embedded.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/i2c_sram_pkg.sv
// i2c_sram_pkg: shared widths and FSM state codes for the I2C SRAM slave
package i2c_sram_pkg;
    localparam int DEV_AW = 7;
    localparam int MEM_AW = 8;
    localparam int DW     = 16;
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV_ADDR  = 4'd1,
        DEV_ACK   = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_ACK   = 4'd4,
        WR_HI     = 4'd5,
        WR_HI_ACK = 4'd6,
        WR_LO     = 4'd7,
        WR_LO_ACK = 4'd8,
        RD_HI     = 4'd9,
        RD_HI_ACK = 4'd10,
        RD_LO     = 4'd11,
        RD_LO_ACK = 4'd12,
        WAIT_STOP = 4'd13
    } state_e;
endpackage

// File: rtl/i2c_sram_embedded_sram.sv
// sram: 256 x 16 single-port memory, synchronous write, registered read
module sram
    import i2c_sram_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [DW-1:0]     din,
    output logic [DW-1:0]     dout
);
    logic [DW-1:0] mem [0:(1<<MEM_AW)-1];
    // write on we; read data appears one cycle after the address
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout <= mem[addr];
    end
endmodule

// File: rtl/i2c_sram_embedded.sv
// i2c_sram_embedded: two-wire slave that reads/writes one 16-bit SRAM word per transaction
module i2c_sram_embedded
    import i2c_sram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    inout  wire               sda,
    input  logic              scl,
    input  logic [DEV_AW-1:0] my_addr,
    output logic [7:0]        curr_data,
    output logic [DEV_AW-1:0] rcvd_device_address,
    output logic [32:0]       state,
    output logic              rcvd_mode
);
    logic [1:0] scl_sync_q, sda_sync_q;
    logic scl_prev_q, sda_prev_q;
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] curr_q, curr_d;
    logic [DEV_AW-1:0] dev_q, dev_d;
    logic mode_q, mode_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] data_write_q, data_write_d, data_read;
    logic we_q, we_d, oe_q, oe_d;
    logic scl_rise, scl_fall, start_c, stop_c, bit_state, rx_state;
    logic [7:0] byte_c;

    assign scl_rise  = scl_sync_q[1] & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q[1] & scl_prev_q;
    assign start_c   = scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
    assign stop_c    = scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];
    assign byte_c    = {curr_q[6:0], sda_sync_q[1]};
    assign rx_state  = state_q inside {DEV_ADDR, MEM_ADDR, WR_HI, WR_LO};
    assign bit_state = rx_state | (state_q inside {RD_HI, RD_LO});

    assign sda                 = oe_q ? 1'b0 : 1'bz;
    assign curr_data           = curr_q;
    assign rcvd_device_address = dev_q;
    assign rcvd_mode           = mode_q;
    assign state               = {29'd0, state_q};

    sram U_SRAM (
        .clk  (clk),
        .we   (we_q),
        .addr (mem_addr_q),
        .din  (data_write_q),
        .dout (data_read)
    );

    // bus synchronizers, edge history and FSM state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync_q   <= 2'b11;
            sda_sync_q   <= 2'b11;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            curr_q       <= '0;
            dev_q        <= '0;
            mode_q       <= 1'b0;
            mem_addr_q   <= '0;
            data_write_q <= '0;
            we_q         <= 1'b0;
            oe_q         <= 1'b0;
        end else begin
            scl_sync_q   <= {scl_sync_q[0], scl};
            sda_sync_q   <= {sda_sync_q[0], sda};
            scl_prev_q   <= scl_sync_q[1];
            sda_prev_q   <= sda_sync_q[1];
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            curr_q       <= curr_d;
            dev_q        <= dev_d;
            mode_q       <= mode_d;
            mem_addr_q   <= mem_addr_d;
            data_write_q <= data_write_d;
            we_q         <= we_d;
            oe_q         <= oe_d;
        end
    end

    // bits are taken on scl rise; state and sda drive advance on scl fall
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        curr_d       = curr_q;
        dev_d        = dev_q;
        mode_d       = mode_q;
        mem_addr_d   = mem_addr_q;
        data_write_d = data_write_q;
        we_d         = 1'b0;
        oe_d         = oe_q;
        if (stop_c) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else if (start_c) begin
            state_d = DEV_ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (scl_rise && bit_state && cnt_q < 4'd8) begin
            cnt_d = cnt_q + 4'd1;
            if (rx_state) curr_d = byte_c;
            if (cnt_q == 4'd7) begin
                case (state_q)
                    DEV_ADDR: begin dev_d = curr_q[6:0]; mode_d = sda_sync_q[1]; end
                    MEM_ADDR: mem_addr_d = byte_c;
                    WR_HI:    data_write_d[15:8] = byte_c;
                    WR_LO:    begin data_write_d[7:0] = byte_c; we_d = 1'b1; end
                    default:  ;
                endcase
            end
        end else if (scl_fall) begin
            case (state_q)
                DEV_ADDR:  if (cnt_q == 4'd8) begin state_d = DEV_ACK; oe_d = dev_q == my_addr; end
                DEV_ACK:   begin state_d = dev_q == my_addr ? MEM_ADDR : WAIT_STOP; oe_d = 1'b0; cnt_d = '0; end
                MEM_ADDR:  if (cnt_q == 4'd8) begin state_d = MEM_ACK; oe_d = 1'b1; end
                MEM_ACK:   begin
                    state_d = mode_q ? RD_HI : WR_HI;
                    curr_d  = mode_q ? data_read[15:8] : curr_q;
                    oe_d    = mode_q & ~data_read[15];
                    cnt_d   = '0;
                end
                WR_HI:     if (cnt_q == 4'd8) begin state_d = WR_HI_ACK; oe_d = 1'b1; end
                WR_HI_ACK: begin state_d = WR_LO; oe_d = 1'b0; cnt_d = '0; end
                WR_LO:     if (cnt_q == 4'd8) begin state_d = WR_LO_ACK; oe_d = 1'b1; end
                WR_LO_ACK: begin state_d = WAIT_STOP; oe_d = 1'b0; end
                RD_HI, RD_LO: begin
                    state_d = cnt_q == 4'd8 ? (state_q == RD_HI ? RD_HI_ACK : RD_LO_ACK) : state_q;
                    oe_d    = cnt_q == 4'd8 ? 1'b0 : ~curr_q[6];
                    curr_d  = cnt_q == 4'd8 ? curr_q : {curr_q[6:0], 1'b0};
                end
                RD_HI_ACK: begin state_d = RD_LO; curr_d = data_read[7:0]; oe_d = ~data_read[7]; cnt_d = '0; end
                RD_LO_ACK: begin state_d = WAIT_STOP; oe_d = 1'b0; end
                default:   ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_sram_embedded.sv
// tb_i2c_sram_embedded: bit-banged bus master with a word-level memory model
module tb_i2c_sram_embedded;
    logic clk = 1'b0, reset = 1'b0, scl = 1'b1, m_oe = 1'b0;
    logic [6:0] my_addr = 7'h3C;
    wire sda;
    logic [7:0] curr_data;
    logic [6:0] rcvd_device_address;
    logic [32:0] state;
    logic rcvd_mode;
    int errors = 0, checks = 0;
    logic [15:0] mem_m [256];
    bit written [256];
    int addr_q[$];

    assign sda = m_oe ? 1'b0 : 1'bz;
    pullup (sda);
    always #5 clk = ~clk;

    i2c_sram_embedded dut (
        .clk                 (clk),
        .reset               (reset),
        .sda                 (sda),
        .scl                 (scl),
        .my_addr             (my_addr),
        .curr_data           (curr_data),
        .rcvd_device_address (rcvd_device_address),
        .state               (state),
        .rcvd_mode           (rcvd_mode)
    );

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start;
        m_oe = 1'b0; tick(4); scl = 1'b1; tick(6); m_oe = 1'b1; tick(6); scl = 1'b0; tick(4);
    endtask

    task automatic bus_stop;
        m_oe = 1'b1; tick(4); scl = 1'b1; tick(6); m_oe = 1'b0; tick(6);
    endtask

    task automatic send_bit(input logic b);
        m_oe = ~b; tick(4); scl = 1'b1; tick(6); scl = 1'b0; tick(2);
    endtask

    task automatic recv_bit(output logic b);
        m_oe = 1'b0; tick(4); scl = 1'b1; tick(3); b = sda; tick(3); scl = 1'b0; tick(2);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(ack);
    endtask

    task automatic do_write(input logic [6:0] dev, input logic [7:0] ma, input logic [15:0] d, input int nb);
        logic [3:0] ack, exp;
        logic match;
        match = dev == my_addr;
        ack = 4'hF;
        exp = 4'hF;
        if (match) begin
            exp[1:0] = 2'b00;
            if (nb > 0) exp[2] = 1'b0;
            if (nb > 1) exp[3] = 1'b0;
        end
        bus_start;
        send_byte({dev, 1'b0}, ack[0]);
        send_byte(ma, ack[1]);
        if (nb > 0) send_byte(d[15:8], ack[2]);
        if (nb > 1) send_byte(d[7:0], ack[3]);
        bus_stop;
        check("wr_acks", ack, exp);
        check("wr_state_idle", state, 0);
        check("wr_rcvd_dev", rcvd_device_address, dev);
        if (match && nb == 2) begin
            mem_m[ma] = d;
            if (!written[ma]) addr_q.push_back(ma);
            written[ma] = 1'b1;
        end
        if (written[ma]) check("wr_mem", dut.U_SRAM.mem[ma], mem_m[ma]);
    endtask

    task automatic do_read(input logic [7:0] ma);
        logic a0, a1;
        logic [7:0] hi, lo;
        bus_start;
        send_byte({my_addr, 1'b1}, a0);
        send_byte(ma, a1);
        recv_byte(1'b0, hi);
        recv_byte(1'b1, lo);
        bus_stop;
        check("rd_acks", {a0, a1}, 2'b00);
        check("rd_data", {hi, lo}, mem_m[ma]);
        check("rd_mode", rcvd_mode, 1'b1);
        check("rd_dev", rcvd_device_address, my_addr);
        check("rd_state_idle", state, 0);
    endtask

    initial begin
        logic a;
        logic b;
        tick(4);
        check("rst_state", state, 0);
        check("rst_curr", curr_data, 0);
        check("rst_dev", rcvd_device_address, 0);
        check("rst_mode", rcvd_mode, 0);
        check("rst_sda", sda, 1'b1);
        reset = 1'b1;
        tick(4);

        do_write(7'h3C, 8'h7C, 16'h5093, 2);
        do_read(8'h7C);
        do_write(7'h3C, 8'h7C, 16'h04D2, 2);
        do_read(8'h7C);
        do_read(8'h7C);

        bus_start;
        send_byte({7'h3D, 1'b0}, a);
        check("nak_dev_ack", a, 1'b1);
        tick(4);
        check("nak_wait_state", state, 13);
        send_byte(8'h7C, a);
        check("nak_mem_ack", a, 1'b1);
        check("nak_wait_state2", state, 13);
        bus_stop;
        check("nak_idle", state, 0);
        check("nak_mem", dut.U_SRAM.mem[8'h7C], 16'h04D2);

        do_write(7'h3C, 8'h7C, 16'hBEEF, 1);
        do_read(8'h7C);

        bus_start;
        send_byte({7'h3C, 1'b1}, a);
        send_byte(8'h7C, a);
        for (int i = 0; i < 3; i++) recv_bit(b);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("midrst_state", state, 0);
        check("midrst_sda", sda, 1'b1);
        check("midrst_mode", rcvd_mode, 1'b0);
        tick(2);
        bus_stop;
        do_write(7'h3C, 8'h10, 16'hA5A5, 2);
        do_read(8'h10);

        for (int k = 0; k < 24; k++) begin
            int op;
            op = $urandom_range(0, 3);
            case (op)
                0: do_write(my_addr, 8'($urandom), 16'($urandom), 2);
                1: do_write(my_addr, 8'($urandom), 16'($urandom), 1);
                2: do_write(my_addr ^ 7'($urandom_range(1, 127)), 8'($urandom), 16'($urandom), 2);
                default: do_read(8'(addr_q[$urandom_range(0, addr_q.size() - 1)]));
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
